// File: rtl/nios_mem_arbiter_pkg.sv
// Shared types and default sizing for the two-master on-chip RAM arbiter.
package nios_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_DEPTH    = 33000;
  localparam int unsigned DEF_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/nios_mem_rr_grant.sv
// Round-robin grant with a bounded hold: the owner keeps the RAM for at most
// MAX_HOLD consecutive grants while the other master is waiting.
module nios_mem_rr_grant
  import nios_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic [1:0]        req_i,
  input  arb_state_e        state_i,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic              last_grant_i,
  output logic [1:0]        grant_o,
  output arb_state_e        state_d_o,
  output logic [HOLD_W-1:0] hold_d_o
);

  logic owner;
  logic winner;

  assign owner = (state_i == ST_OWN1);

  always_comb begin
    grant_o   = 2'b00;
    state_d_o = ST_IDLE;
    hold_d_o  = '0;
    winner    = 1'b0;

    unique case (req_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11: begin
        // In IDLE the master not served last wins; otherwise the hold limit decides.
        if (state_i == ST_IDLE)                    winner = ~last_grant_i;
        else if (hold_i < HOLD_W'(MAX_HOLD))       winner = owner;
        else                                       winner = ~owner;
      end
      default: winner = 1'b0;
    endcase

    if (|req_i) begin
      grant_o   = winner ? 2'b10 : 2'b01;
      state_d_o = winner ? ST_OWN1 : ST_OWN0;
      if ((state_i != ST_IDLE) && (winner == owner)) begin
        hold_d_o = (hold_i >= HOLD_W'(MAX_HOLD)) ? hold_i : hold_i + HOLD_W'(1);
      end else begin
        hold_d_o = HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/nios_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port synchronous RAM,
// with range checking and read-return routing by a registered owner tag.
module nios_mem_arbiter
  import nios_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                err_oor
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              last_grant_q, last_grant_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              rd_oor_q, rd_oor_d;
  logic              err_oor_q, err_oor_d;

  logic [1:0]        req;
  logic [1:0]        grant_raw;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic              cmd_oor;
  logic [DATA_W-1:0] rd_data;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  nios_mem_rr_grant #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_grant (
    .req_i        (req),
    .state_i      (state_q),
    .hold_i       (hold_q),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_raw),
    .state_d_o    (state_d),
    .hold_d_o     (hold_d)
  );

  // Nothing is granted while reset is held, so both masters stall.
  assign grant  = reset ? 2'b00 : grant_raw;
  assign accept = |grant;
  assign sel    = grant[1];

  assign m0_waitrequest = reset | (req[0] & ~grant[0]);
  assign m1_waitrequest = reset | (req[1] & ~grant[1]);

  assign cmd_addr  = sel ? m1_address : m0_address;
  assign cmd_write = sel ? m1_write : m0_write;
  assign cmd_oor   = 64'(cmd_addr) >= 64'(DEPTH);

  assign ram_address    = cmd_addr;
  assign ram_byteenable = sel ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = sel ? m1_writedata : m0_writedata;
  assign ram_chipselect = accept & ~cmd_oor;
  assign ram_write      = accept & ~cmd_oor & cmd_write;
  assign ram_clken      = 1'b1;

  // Write wins when read and write are both asserted, so only pure reads return data.
  always_comb begin
    rd_pend_d    = accept & ~cmd_write;
    rd_owner_d   = sel;
    rd_oor_d     = cmd_oor;
    err_oor_d    = err_oor_q | (accept & cmd_oor);
    last_grant_d = accept ? sel : last_grant_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      rd_oor_q     <= 1'b0;
      err_oor_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      rd_oor_q     <= rd_oor_d;
      err_oor_q    <= err_oor_d;
    end
  end

  assign rd_data          = rd_oor_q ? '0 : ram_readdata;
  assign m0_readdatavalid = rd_pend_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q & rd_owner_q;
  assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
  assign m1_readdata      = m1_readdatavalid ? rd_data : '0;
  assign err_oor          = err_oor_q;

endmodule
